// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder cell, LSB first, carry held in a flop.
// Optional subtract mode (a - b) is enabled by defining SERIAL_ADDER_SUB_EN.

module fa (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);

endmodule

module serial_adder #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         ovf
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   opa_q, opa_d;
  logic [N-1:0]   opb_q, opb_d;
  logic [N-1:0]   res_q, res_d;
  logic [N-1:0]   sum_q, sum_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           carry_q, carry_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           fa_s_c;
  logic           fa_co_c;
  logic [N-1:0]   b_eff_c;
  logic           cin_eff_c;

  // Operand B / carry-in as loaded on start (inverted B plus one for subtract)
`ifdef SERIAL_ADDER_SUB_EN
  always_comb begin
    b_eff_c   = sub ? ~b : b;
    cin_eff_c = sub ? 1'b1 : c_in;
  end
`else
  always_comb begin
    b_eff_c   = b;
    cin_eff_c = c_in;
  end
`endif

  fa u_fa (
    .a_i  (opa_q[0]),
    .b_i  (opb_q[0]),
    .ci_i (carry_q),
    .s_o  (fa_s_c),
    .co_o (fa_co_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b_eff_c;
          carry_d = cin_eff_c;
          cnt_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end

      RUN: begin
        busy_d  = 1'b1;
        res_d   = {fa_s_c, res_q[N-1:1]};
        opa_d   = {1'b0, opa_q[N-1:1]};
        opb_d   = {1'b0, opb_q[N-1:1]};
        carry_d = fa_co_c;
        cnt_d   = cnt_q + CW'(1);
        // Last bit: carry_q is the carry into the MSB, fa_co_c the carry out of it
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          sum_d   = {fa_s_c, res_q[N-1:1]};
          cout_d  = fa_co_c;
          ovf_d   = carry_q ^ fa_co_c;
          cnt_d   = '0;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = cout_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder; subtract cases run when SERIAL_ADDER_SUB_EN is defined.

module tb_serial_adder;

  localparam int unsigned N = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         c_in;
  logic         sub;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         c_out;
  logic         ovf;

  int n_checks;
  int n_errors;
  int done_cnt;
  int exp_done;

  logic [N-1:0] last_sum;
  logic [N+1:0] exp_q[$];

  serial_adder #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference result packed as {ovf, c_out, sum}
  function automatic logic [N+1:0] model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                         input logic mcin, input logic msub);
    logic [N-1:0] bb;
    logic         cc;
    logic [N:0]   full;
    logic         v;
    bb   = msub ? ~mb : mb;
    cc   = msub ? 1'b1 : mcin;
    full = {1'b0, ma} + {1'b0, bb} + {{N{1'b0}}, cc};
    v    = (ma[N-1] == bb[N-1]) && (full[N-1] != ma[N-1]);
    return {v, full[N], full[N-1:0]};
  endfunction

  task automatic do_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic tcin,
                       input logic tsub, input int inject_at, input int reset_at,
                       input bit scramble);
    int n;
    int nbusy;
    bit seen;
    logic [N+1:0] e;
    @(negedge clk);
    a     = ta;
    b     = tb_v;
    c_in  = tcin;
    sub   = tsub;
    start = 1'b1;
    exp_q.push_back(model(ta, tb_v, tcin, tsub));
    n     = 0;
    nbusy = 0;
    seen  = 0;
    while (!seen && n < int'(N) + 10) begin
      @(negedge clk);
      n++;
      start = (n == inject_at);
      if (start) begin
        a    = N'(1);
        b    = N'(1);
        c_in = 1'b0;
      end else if (scramble) begin
        a    = N'($urandom);
        b    = N'($urandom);
        c_in = 1'($urandom);
      end
      if (n == reset_at) begin
        reset = 1'b1;
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_sum", 32'(sum), 32'd0);
        check_eq("rst_cout", 32'(c_out), 32'd0);
        check_eq("rst_ovf", 32'(ovf), 32'd0);
        void'(exp_q.pop_front());
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_idle_busy", 32'(busy), 32'd0);
        check_eq("rst_idle_done", 32'(done), 32'd0);
        last_sum = '0;
        return;
      end
      if (n == 1) check_eq("hold_sum", 32'(sum), 32'(last_sum));
      if (busy) nbusy++;
      if (done) begin
        seen = 1;
        check_eq("latency", 32'(n), 32'(N + 1));
        check_eq("busy_cycles", 32'(nbusy), 32'(N));
        if (exp_q.size() == 0) begin
          check_eq("sb_empty", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          check_eq("sum", 32'(sum), 32'(e[N-1:0]));
          check_eq("c_out", 32'(c_out), 32'(e[N]));
          check_eq("ovf", 32'(ovf), 32'(e[N+1]));
          last_sum = e[N-1:0];
        end
      end
    end
    if (!seen) begin
      check_eq("done_timeout", 32'd0, 32'd1);
    end else begin
      exp_done++;
      @(negedge clk);
      check_eq("done_pulse", 32'(done), 32'd0);
      check_eq("sum_hold", 32'(sum), 32'(last_sum));
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    done_cnt = 0;
    exp_done = 0;
    last_sum = '0;
    reset    = 1'b1;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    c_in     = 1'b0;
    sub      = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);
    check_eq("reset_sum", 32'(sum), 32'd0);
    check_eq("reset_cout", 32'(c_out), 32'd0);
    check_eq("reset_ovf", 32'(ovf), 32'd0);
    reset = 1'b0;

    do_op(8'h5A, 8'h33, 1'b0, 1'b0, 0, 0, 0);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, 0, 0);
    do_op(8'h7F, 8'h00, 1'b1, 1'b0, 0, 0, 0);
    do_op(8'h22, 8'h44, 1'b0, 1'b0, 3, 0, 0);
    do_op(8'h5A, 8'h33, 1'b0, 1'b0, 0, 4, 0);
    do_op(8'h10, 8'h20, 1'b0, 1'b0, 0, 0, 0);
    do_op(8'hC3, 8'h5E, 1'b1, 1'b0, 0, 0, 1);
    for (int i = 0; i < 6; i++)
      do_op(N'($urandom), N'($urandom), 1'($urandom), 1'b0, 0, 0, (i % 2) == 1);
`ifdef SERIAL_ADDER_SUB_EN
    do_op(8'h10, 8'h20, 1'b0, 1'b1, 0, 0, 0);
    do_op(8'h80, 8'h01, 1'b0, 1'b1, 0, 0, 0);
    do_op(8'h33, 8'h33, 1'b1, 1'b1, 0, 0, 1);
    for (int i = 0; i < 4; i++)
      do_op(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom), 0, 0, 0);
`endif

    repeat (4) @(negedge clk);
    check_eq("done_count", 32'(done_cnt), 32'(exp_done));
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    check_eq("final_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
